// File: rtl/result_uart_tx.sv
// Frames one captured hasher result into a SYNC/payload/XOR-checksum packet, sent 8N1 on tx.
// Define RESULT_TX_HASH_EN to include the 256-bit hash in the packet (42 bytes); otherwise 10 bytes.
module result_uart_tx #(
  parameter int          CLKS_PER_BIT = 868,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_in,
  input  logic [31:0]  nonce_in,
  input  logic [31:0]  time_in,
  input  logic [255:0] result_in,
  output logic         tx,
  output logic         busy,
  output logic [7:0]   drop_cnt
);

`ifdef RESULT_TX_HASH_EN
  localparam int NBYTES = 42;
  localparam int SHW    = 320;
`else
  localparam int NBYTES = 10;
  localparam int SHW    = 64;
`endif

  localparam int             BW        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [5:0]     BYTE_LAST = 6'(NBYTES - 1);
  localparam logic [5:0]     CSUM_PREV = 6'(NBYTES - 2);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [5:0]      byte_q, byte_d;
  logic [7:0]      data_q, data_d;
  logic [7:0]      csum_q, csum_d;
  logic [SHW-1:0]  shadow_q, shadow_d;
  logic [7:0]      drop_q, drop_d;
  logic            tx_q, tx_d;
  logic [SHW-1:0]  shadow_in;

`ifdef RESULT_TX_HASH_EN
  assign shadow_in = {nonce_in, time_in, result_in};
`else
  logic unused_result;
  assign shadow_in     = {nonce_in, time_in};
  assign unused_result = ^result_in;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      byte_q   <= '0;
      data_q   <= '0;
      csum_q   <= '0;
      shadow_q <= '0;
      drop_q   <= '0;
      tx_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      data_q   <= data_d;
      csum_q   <= csum_d;
      shadow_q <= shadow_d;
      drop_q   <= drop_d;
      tx_q     <= tx_d;
    end
  end

  // tx_d is derived from the next state so the pin itself is a flop.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    data_d   = data_q;
    csum_d   = csum_q;
    shadow_d = shadow_q;
    drop_d   = drop_q;
    tx_d     = tx_q;

    if (valid_in && (state_q != S_IDLE) && (drop_q != 8'hFF))
      drop_d = drop_q + 8'd1;

    unique case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (valid_in) begin
          shadow_d = shadow_in;
          data_d   = SYNC_BYTE;
          csum_d   = '0;
          byte_d   = '0;
          baud_d   = '0;
          bit_d    = '0;
          tx_d     = 1'b0;
          state_d  = S_START;
        end
      end
      S_START: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = data_q[0];
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            bit_d  = bit_q + 3'd1;
            data_d = {1'b0, data_q[7:1]};
            tx_d   = data_q[1];
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_STOP: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (byte_q == BYTE_LAST) begin
            tx_d    = 1'b1;
            state_d = S_IDLE;
          end else begin
            // Payload streams out of the top of the shadow; checksum folds in each byte as loaded.
            byte_d  = byte_q + 6'd1;
            tx_d    = 1'b0;
            state_d = S_START;
            if (byte_q == CSUM_PREV) begin
              data_d = csum_q;
            end else begin
              data_d   = shadow_q[SHW-1 -: 8];
              csum_d   = csum_q ^ shadow_q[SHW-1 -: 8];
              shadow_d = {shadow_q[SHW-9:0], 8'h00};
            end
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign tx       = tx_q;
  assign busy     = (state_q != S_IDLE);
  assign drop_cnt = drop_q;

endmodule

// File: doc/result_uart_tx.md
Name: result_uart_tx

Overview:
- Serialises hasher solutions to the host over a UART link: the result-reporting counterpart to the serial job-loading input.
- Captures one result (nonce, time, 256-bit hash) on the hasher's valid pulse and frames it into a fixed byte packet.
- Transmits the packet 8N1 on a single tx pin; the board top level instantiates it alongside the hasher, next to the LED status logic.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); legal values 2 and up.
- SYNC_BYTE, 8'hA5, first byte of every packet.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- valid_in  in  1  one-cycle pulse from hasher: solution present on data inputs
- nonce_in  in  32  winning nonce
- time_in  in  32  block time used
- result_in  in  256  resulting hash
- tx  out  1  UART serial output, idle high
- busy  out  1  high while a packet is being transmitted
- drop_cnt  out  8  count of valid_in pulses rejected while busy; saturating

Behaviour:
- Reset values:
  - tx=1, busy=0, drop_cnt=0.
  - FSM in IDLE, all counters zero.
  - Reset mid-packet aborts immediately; tx=1 from the next edge. The truncated frame is acceptable: the host resyncs on SYNC_BYTE.
- Capture:
  - valid_in with busy==0 latches nonce_in, time_in and result_in into a shadow register in the same edge.
  - Later input changes do not affect the packet in flight.
- Drop:
  - valid_in with busy==1 leaves the shadow register untouched and increments drop_cnt, saturating at 255.
  - valid_in on the final stop-bit cycle is also dropped, because busy is still 1.
- Packet byte order, each byte sent LSB-first on the wire:
  - SYNC_BYTE.
  - nonce bytes, MSB byte first (4).
  - time bytes, MSB byte first (4).
  - result bytes, MSB byte first (32).
  - checksum.
  - Total 42 bytes.
- Checksum: XOR of all payload bytes, excluding SYNC_BYTE. Accumulated as each byte is loaded.
- Frame per byte:
  - Start bit 0, data[0..7], stop bit 1, each exactly CLKS_PER_BIT cycles.
  - No idle gap between bytes within a packet.
- FSM:
  - IDLE -> START on accept.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> STOP after 8 bits.
  - STOP -> START if bytes remain, else IDLE.
  - Counters: baud counter 0..CLKS_PER_BIT-1, bit index 0..7, byte index 0..NBYTES-1.
- Timing:
  - Accept at edge N: busy=1 and tx=0 (start bit) from edge N+1.
  - busy returns to 0 at edge N+1+NBYTES*10*CLKS_PER_BIT.
  - A new valid_in is accepted on that cycle or later.
- tx is a registered output: no combinational path from any input.

Optional Feature:
- Macro: RESULT_TX_HASH_EN.
- Defined:
  - Packet includes the 32 result bytes; NBYTES=42.
  - The checksum covers nonce, time and result.
- Undefined:
  - result_in is ignored and not stored; no 256-bit shadow register.
  - Packet is SYNC, nonce(4), time(4), checksum; NBYTES=10.
  - The checksum covers nonce and time only.

Test Plan (CLKS_PER_BIT=4, RESULT_TX_HASH_EN defined unless stated):
- Reset 5 cycles, no valid_in -> tx=1, busy=0, drop_cnt=0 throughout 100 cycles.
- valid_in pulse with nonce=32'h12345678, time=32'h130DAE51, result=0 -> bytes are A5 12 34 56 78 13 0D AE 51, then 32x 00, then E9.
  - tx low at accept+1, each bit 4 cycles wide.
  - busy falls exactly 1680 cycles after the tx start edge.
- Second valid_in 100 cycles after the first -> drop_cnt=1, packet contents unchanged.
  - 300 further pulses while busy -> drop_cnt=255.
- Change all inputs on the cycle after accept -> transmitted packet still carries the originally captured values.
- Assert rst in the middle of byte 7 -> tx=1 and busy=0 next cycle.
  - A fresh valid_in afterwards yields a complete, correct packet starting with A5.
- Macro undefined, same stimulus as scenario 2 -> 10 bytes: A5 12 34 56 78 13 0D AE 51 E9; busy high for 400 cycles.
